// File: rtl/spi_eeprom_ctrl.sv
// spi_eeprom_ctrl: mode-0 SPI master for 25xx serial EEPROMs.
// Single-byte read/write with WREN prefix and RDSR polling.
module spi_eeprom_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_GAP   = 2,
  parameter int unsigned POLL_MAX = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  dev_sel,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  sel,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  localparam int unsigned GAP_N =
    (CS_GAP * CLK_DIV > 0) ? CS_GAP * CLK_DIV : 1;
  localparam int unsigned CNT_MAX =
    (GAP_N > CLK_DIV) ? GAP_N : CLK_DIV;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_N - 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_XFER, S_POLL, S_GAP, S_FIN
  } state_e;

  // LO/HI: sck half-periods; TAIL: cs_n hold after
  // last fall; END: one cs_n-high cycle closing the frame.
  typedef enum logic [1:0] {
    P_LO, P_HI, P_TAIL, P_END
  } phase_e;

  state_e        state_q, state_d;
  phase_e        ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [31:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          rw_q, rw_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          to_xfer_q, to_xfer_d;
  logic          enter;
  logic          half_end;
  logic [5:0]    last_idx;

  // Next-state and next-output logic for the whole controller
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    poll_d    = poll_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    to_xfer_d = to_xfer_q;
    enter     = 1'b0;
    half_end  = (cnt_q == HALF_END);

    unique case (state_q)
      S_WREN:  last_idx = 6'd7;
      S_POLL:  last_idx = 6'd15;
      default: last_idx = 6'd31;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rw_d    = rw;
          sel_d   = dev_sel;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          poll_d  = '0;
          busy_d  = 1'b1;
          enter   = 1'b1;
          state_d = rw ? S_WREN : S_XFER;
          tx_d    = rw ? {OP_WREN, 24'h0}
                       : {OP_READ, addr, 8'h00};
        end
      end
      S_WREN, S_XFER, S_POLL: begin
        cnt_d = cnt_q + 1'b1;
        unique case (ph_q)
          P_LO: begin
            if (half_end) begin
              cnt_d = '0;
              sck_d = 1'b1;
              rx_d  = {rx_q[6:0], miso};
              ph_d  = P_HI;
            end
          end
          P_HI: begin
            if (half_end) begin
              cnt_d  = '0;
              sck_d  = 1'b0;
              tx_d   = {tx_q[30:0], 1'b0};
              mosi_d = tx_q[30];
              if (bit_q == last_idx) begin
                ph_d = P_TAIL;
              end else begin
                bit_d = bit_q + 1'b1;
                ph_d  = P_LO;
              end
            end
          end
          P_TAIL: begin
            if (half_end) begin
              cnt_d  = '0;
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
              ph_d   = P_END;
            end
          end
          default: begin
            cnt_d = '0;
            if (state_q == S_WREN) begin
              state_d   = S_GAP;
              to_xfer_d = 1'b1;
            end else if (state_q == S_XFER) begin
              if (rw_q) begin
                state_d   = S_GAP;
                to_xfer_d = 1'b0;
              end else begin
                state_d = S_FIN;
                rdata_d = rx_q;
              end
            end else begin
              if (poll_q != POLL_LIM) begin
                poll_d = poll_q + 1'b1;
              end
              if (!rx_q[0]) begin
                state_d = S_FIN;
              end else if (poll_d == POLL_LIM) begin
                state_d = S_FIN;
                err_d   = 1'b1;
              end else begin
                state_d   = S_GAP;
                to_xfer_d = 1'b0;
              end
            end
          end
        endcase
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_END) begin
          enter   = 1'b1;
          state_d = to_xfer_q ? S_XFER : S_POLL;
          tx_d    = to_xfer_q
                    ? {OP_WRITE, addr_q, wdata_q}
                    : {OP_RDSR, 24'h0};
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_FIN) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    // A new frame starts with cs_n low and bit 31 on mosi.
    if (enter) begin
      cnt_d  = '0;
      bit_d  = '0;
      ph_d   = P_LO;
      cs_n_d = 1'b0;
      sck_d  = 1'b0;
      mosi_d = tx_d[31];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= P_LO;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  // Datapath and registered SPI/handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      poll_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      to_xfer_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      poll_q    <= poll_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      to_xfer_q <= to_xfer_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign sel   = sel_q;
  assign cs_n  = cs_n_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_eeprom_ctrl.sv
// tb_spi_eeprom_ctrl: scoreboard bench with an EEPROM miso model.
// Frames and done responses are queued at issue, checked by monitors.
module tb_spi_eeprom_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  dev_sel = '0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        busy, done, err;
  logic [1:0]  sel;
  logic        cs_n, sck, mosi;
  logic        miso = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          len;
    logic [31:0] val;
  } frame_t;

  typedef struct {
    bit          has_rd;
    logic [7:0]  rd;
    logic        er;
    logic [1:0]  sl;
  } resp_t;

  frame_t fq[$];
  resp_t  rq[$];

  logic [7:0] rd_byte = '0;
  int         wip_left = 0;
  bit         wip_stuck = 1'b0;

  spi_eeprom_ctrl #(
    .CLK_DIV (2),
    .CS_GAP  (2),
    .POLL_MAX(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rw     (rw),
    .dev_sel(dev_sel),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .sel    (sel),
    .cs_n   (cs_n),
    .sck    (sck),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // SPI monitor plus EEPROM response model
  logic [31:0] cap = '0;
  int          nbits = 0;
  logic [7:0]  op = '0;
  bit          psck = 1'b0;
  bit          pcs = 1'b1;
  bit          in_txn = 1'b0;
  int          hi_cnt = 0;
  frame_t      f;

  always @(negedge clk) begin
    if (rst) begin
      nbits  = 0;
      cap    = '0;
      op     = '0;
      psck   = 1'b0;
      pcs    = 1'b1;
      in_txn = 1'b0;
      hi_cnt = 0;
      miso   = 1'b0;
    end else begin
      if (!cs_n && pcs) begin
        if (in_txn)
          chk("cs_gap_ge4", 32'(hi_cnt >= 4), 32'd1);
        nbits = 0;
        cap   = '0;
        op    = '0;
      end
      if (cs_n) hi_cnt++;
      if (sck && !psck) begin
        cap = {cap[30:0], mosi};
        nbits++;
        if (nbits == 8) op = cap[7:0];
      end
      if (!sck && psck) begin
        if (op == 8'h03 && nbits >= 24 && nbits < 32)
          miso = rd_byte[3'(31 - nbits)];
        else if (op == 8'h05 && nbits == 15)
          miso = wip_stuck || (wip_left > 0);
        else
          miso = 1'b0;
      end
      if (cs_n && !pcs) begin
        hi_cnt = 1;
        in_txn = busy;
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %0d bits %h, expected none",
                   nbits, cap);
        end else begin
          f = fq.pop_front();
          chk("frame_len", 32'(nbits), 32'(f.len));
          chk("frame_bits", cap, f.val);
        end
        if (op == 8'h05 && !wip_stuck && wip_left > 0)
          wip_left--;
      end
      if (done) in_txn = 1'b0;
      psck = sck;
      pcs  = cs_n;
    end
  end

  // Done monitor: pops the expected response per done pulse
  resp_t r;

  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_busy_low", 32'(busy), 32'd0);
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done, expected none");
      end else begin
        r = rq.pop_front();
        if (r.has_rd) chk("rdata", 32'(rdata), 32'(r.rd));
        chk("err", 32'(err), 32'(r.er));
        chk("sel", 32'(sel), 32'(r.sl));
      end
    end
  end

  task automatic issue(input bit w, input logic [1:0] ds,
                       input logic [15:0] a, input logic [7:0] wd);
    @(negedge clk);
    rw      = w;
    dev_sel = ds;
    addr    = a;
    wdata   = wd;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done, expected within %0d cycles", n);
    end
  endtask

  initial begin
    int rise_c;
    int done_c;
    bit sel_ok;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    rst = 1'b0;

    // Abort a read mid-frame with an asynchronous reset.
    rd_byte = 8'h99;
    issue(1'b0, 2'd1, 16'h5555, 8'h00);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    rd_byte = 8'h77;
    fq.push_back('{32, 32'h0300_1000});
    rq.push_back('{1'b1, 8'h77, 1'b0, 2'd2});
    issue(1'b0, 2'd2, 16'h0010, 8'h00);
    wait_done(400);

    // Read with exact latency checks.
    rd_byte = 8'hA5;
    fq.push_back('{32, 32'h0312_3400});
    rq.push_back('{1'b1, 8'hA5, 1'b0, 2'd1});
    issue(1'b0, 2'd1, 16'h1234, 8'h00);
    chk("rd_cs_n_c1", 32'(cs_n), 32'd0);
    chk("rd_busy_c1", 32'(busy), 32'd1);
    rise_c = 0;
    done_c = 0;
    sel_ok = 1'b1;
    for (int c = 2; c < 400 && done_c == 0; c++) begin
      @(negedge clk);
      if (sel !== 2'd1) sel_ok = 1'b0;
      if (cs_n && rise_c == 0) rise_c = c;
      if (done) done_c = c;
    end
    chk("rd_cs_n_rise_cycle", 32'(rise_c), 32'd131);
    chk("rd_done_cycle", 32'(done_c), 32'd132);
    chk("rd_sel_stable", 32'(sel_ok), 32'd1);

    // Write: WIP stays set for three polls.
    wip_left  = 3;
    wip_stuck = 1'b0;
    fq.push_back('{8, 32'h06});
    fq.push_back('{32, 32'h0200_FF5A});
    repeat (4) fq.push_back('{16, 32'h0500});
    rq.push_back('{1'b0, 8'h00, 1'b0, 2'd0});
    issue(1'b1, 2'd0, 16'h00FF, 8'h5A);
    wait_done(3000);

    // Write whose WIP never clears.
    wip_stuck = 1'b1;
    fq.push_back('{8, 32'h06});
    fq.push_back('{32, 32'h0201_0011});
    repeat (8) fq.push_back('{16, 32'h0500});
    rq.push_back('{1'b0, 8'h00, 1'b1, 2'd3});
    issue(1'b1, 2'd3, 16'h0100, 8'h11);
    wait_done(5000);
    wip_stuck = 1'b0;

    // Read with a stray start mid-frame; err must clear.
    rd_byte = 8'h3C;
    fq.push_back('{32, 32'h0300_4000});
    rq.push_back('{1'b1, 8'h3C, 1'b0, 2'd0});
    issue(1'b0, 2'd0, 16'h0040, 8'h00);
    chk("err_cleared", 32'(err), 32'd0);
    repeat (30) @(negedge clk);
    rw      = 1'b1;
    dev_sel = 2'd3;
    addr    = 16'hFFFF;
    wdata   = 8'hEE;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chk("busy_sel_hold", 32'(sel), 32'd0);
    chk("busy_still", 32'(busy), 32'd1);
    wait_done(400);

    // start held over the done cycle and the next idle cycle.
    rd_byte = 8'hC3;
    fq.push_back('{32, 32'h03BE_EF00});
    rq.push_back('{1'b1, 8'hC3, 1'b0, 2'd2});
    rw      = 1'b0;
    dev_sel = 2'd2;
    addr    = 16'hBEEF;
    wdata   = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    chk("fin_start_ignored", 32'(cs_n), 32'd1);
    chk("fin_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_taken", 32'(cs_n), 32'd0);
    chk("idle_busy_high", 32'(busy), 32'd1);
    wait_done(400);

    repeat (4) @(negedge clk);
    chk("frames_left", 32'(fq.size()), 32'd0);
    chk("resp_left", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
